// File: rtl/guess_entry.sv
// Digit-entry stage for 1A2B: edits a BCD guess under a cursor and offers it over valid/ready.
// Optional duplicate-digit check enabled by defining GUESS_ENTRY_DISTINCT_CHECK_EN.
module guess_entry #(
    parameter int unsigned DIGITS = 4,
    parameter bit          WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  btn_up,
    input  logic                  btn_down,
    input  logic                  btn_left,
    input  logic                  btn_right,
    input  logic                  btn_enter,
    input  logic                  btn_clear,
    output logic [4*DIGITS-1:0]   guess,
    output logic [2:0]            cursor,
    output logic                  guess_valid,
    input  logic                  guess_ready,
    output logic                  dup_err,
    output logic [DIGITS-1:0]     dup_mask
);

    localparam logic [2:0] CUR_MSB = 3'(DIGITS - 1);

    typedef enum logic {
        EDIT  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] digits_q [DIGITS];
    logic [3:0] digits_d [DIGITS];
    logic [2:0] cursor_q, cursor_d;

`ifdef GUESS_ENTRY_DISTINCT_CHECK_EN
    logic [DIGITS-1:0] dup_c;
    logic              dup_err_d;
    logic              dup_err_q;
    logic [DIGITS-1:0] dup_mask_q;

    // Pairwise comparator: flag every digit that matches some other digit
    always_comb begin
        dup_c = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            for (int unsigned j = 0; j < DIGITS; j++) begin
                if (i != j && digits_q[i] == digits_q[j]) begin
                    dup_c[i] = 1'b1;
                end
            end
        end
    end
`endif

    // Next-state: clear > enter > digit > cursor, evaluated only in EDIT with en
    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        cursor_d = cursor_q;
`ifdef GUESS_ENTRY_DISTINCT_CHECK_EN
        dup_err_d = 1'b0;
`endif
        case (state_q)
            EDIT: begin
                if (en) begin
                    if (btn_clear) begin
                        for (int unsigned i = 0; i < DIGITS; i++) begin
                            digits_d[i] = 4'(i);
                        end
                        cursor_d = CUR_MSB;
                    end else if (btn_enter) begin
`ifdef GUESS_ENTRY_DISTINCT_CHECK_EN
                        if (|dup_c) begin
                            dup_err_d = 1'b1;
                        end else begin
                            state_d = OFFER;
                        end
`else
                        state_d = OFFER;
`endif
                    end else if (btn_up || btn_down) begin
                        for (int unsigned i = 0; i < DIGITS; i++) begin
                            if (cursor_q == 3'(i)) begin
                                if (btn_up && !btn_down) begin
                                    digits_d[i] = (digits_q[i] == 4'd9) ? 4'd0 : digits_q[i] + 4'd1;
                                end else if (btn_down && !btn_up) begin
                                    digits_d[i] = (digits_q[i] == 4'd0) ? 4'd9 : digits_q[i] - 4'd1;
                                end
                            end
                        end
                    end else if (btn_left && !btn_right) begin
                        cursor_d = (cursor_q == CUR_MSB) ? (WRAP ? 3'd0 : cursor_q) : cursor_q + 3'd1;
                    end else if (btn_right && !btn_left) begin
                        cursor_d = (cursor_q == 3'd0) ? (WRAP ? CUR_MSB : cursor_q) : cursor_q - 3'd1;
                    end
                end
            end
            OFFER: begin
                if (guess_ready) begin
                    state_d = EDIT;
                end
            end
            default: state_d = EDIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EDIT;
            cursor_q <= CUR_MSB;
            for (int unsigned i = 0; i < DIGITS; i++) begin
                digits_q[i] <= 4'(i);
            end
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            digits_q <= digits_d;
        end
    end

`ifdef GUESS_ENTRY_DISTINCT_CHECK_EN
    // dup_mask tracks the digits held during the previous cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            dup_err_q  <= 1'b0;
            dup_mask_q <= '0;
        end else begin
            dup_err_q  <= dup_err_d;
            dup_mask_q <= dup_c;
        end
    end

    assign dup_err  = dup_err_q;
    assign dup_mask = dup_mask_q;
`else
    assign dup_err  = 1'b0;
    assign dup_mask = '0;
`endif

    always_comb begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
            guess[4*i +: 4] = digits_q[i];
        end
    end

    assign cursor      = cursor_q;
    assign guess_valid = (state_q == OFFER);

endmodule

// File: tb/tb_guess_entry.sv
// Bench for guess_entry: directed vector table, hand sequences and randomized model comparison.
// Instance 0 uses WRAP=1, instance 1 uses WRAP=0; both see identical stimulus.
module tb_guess_entry;

    localparam int unsigned D = 4;

    localparam logic [8:0] RST = 9'h100;
    localparam logic [8:0] EN  = 9'h080;
    localparam logic [8:0] UP  = 9'h040;
    localparam logic [8:0] DN  = 9'h020;
    localparam logic [8:0] LF  = 9'h010;
    localparam logic [8:0] RT  = 9'h008;
    localparam logic [8:0] ENT = 9'h004;
    localparam logic [8:0] CLR = 9'h002;
    localparam logic [8:0] RDY = 9'h001;

`ifdef GUESS_ENTRY_DISTINCT_CHECK_EN
    localparam bit CHECK_ON = 1'b1;
`else
    localparam bit CHECK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, en, btn_up, btn_down, btn_left, btn_right, btn_enter, btn_clear, guess_ready;

    logic [4*D-1:0] guess_o    [2];
    logic [2:0]     cursor_o   [2];
    logic           valid_o    [2];
    logic           dup_err_o  [2];
    logic [D-1:0]   dup_mask_o [2];

    int tests  = 0;
    int failed = 0;

    // Reference model state, one copy per WRAP setting
    int       m_dig [2][D];
    int       m_cur [2];
    bit       m_off [2];
    bit       m_err [2];
    logic [D-1:0] m_mask [2];

    always #5 clk = ~clk;

    guess_entry #(.DIGITS(D), .WRAP(1'b1)) dut_wrap (
        .clk(clk), .rst(rst), .en(en),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_enter(btn_enter), .btn_clear(btn_clear),
        .guess(guess_o[0]), .cursor(cursor_o[0]), .guess_valid(valid_o[0]),
        .guess_ready(guess_ready), .dup_err(dup_err_o[0]), .dup_mask(dup_mask_o[0])
    );

    guess_entry #(.DIGITS(D), .WRAP(1'b0)) dut_sat (
        .clk(clk), .rst(rst), .en(en),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_enter(btn_enter), .btn_clear(btn_clear),
        .guess(guess_o[1]), .cursor(cursor_o[1]), .guess_valid(valid_o[1]),
        .guess_ready(guess_ready), .dup_err(dup_err_o[1]), .dup_mask(dup_mask_o[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset(input int w);
        for (int i = 0; i < D; i++) m_dig[w][i] = i;
        m_cur[w] = D - 1;
    endtask

    task automatic model_step(input int w, input logic [8:0] b);
        int cnt[10];
        logic [D-1:0] nm;
        bit wrap;
        wrap = (w == 0);
        for (int v = 0; v < 10; v++) cnt[v] = 0;
        for (int i = 0; i < D; i++) cnt[m_dig[w][i]]++;
        nm = '0;
        for (int i = 0; i < D; i++) nm[i] = (cnt[m_dig[w][i]] > 1);
        if (!CHECK_ON) nm = '0;
        m_err[w] = 1'b0;
        if (b[8]) begin
            model_reset(w);
            m_off[w]  = 1'b0;
            m_mask[w] = '0;
            return;
        end
        m_mask[w] = nm;
        if (m_off[w]) begin
            if (b[0]) m_off[w] = 1'b0;
        end else if (b[7]) begin
            if (b[1]) begin
                model_reset(w);
            end else if (b[2]) begin
                if (nm != 0) m_err[w] = 1'b1;
                else m_off[w] = 1'b1;
            end else if (b[6] || b[5]) begin
                if (b[6] && !b[5]) m_dig[w][m_cur[w]] = (m_dig[w][m_cur[w]] + 1) % 10;
                if (b[5] && !b[6]) m_dig[w][m_cur[w]] = (m_dig[w][m_cur[w]] + 9) % 10;
            end else if (b[4] && !b[3]) begin
                if (m_cur[w] < D - 1) m_cur[w]++;
                else if (wrap) m_cur[w] = 0;
            end else if (b[3] && !b[4]) begin
                if (m_cur[w] > 0) m_cur[w]--;
                else if (wrap) m_cur[w] = D - 1;
            end
        end
    endtask

    task automatic check_model();
        logic [4*D-1:0] g;
        for (int w = 0; w < 2; w++) begin
            g = '0;
            for (int i = 0; i < D; i++) g[4*i +: 4] = 4'(m_dig[w][i]);
            chk("model_guess",    32'(guess_o[w]),    32'(g));
            chk("model_cursor",   32'(cursor_o[w]),   32'(m_cur[w]));
            chk("model_valid",    32'(valid_o[w]),    32'(m_off[w]));
            chk("model_dup_err",  32'(dup_err_o[w]),  32'(m_err[w]));
            chk("model_dup_mask", 32'(dup_mask_o[w]), 32'(m_mask[w]));
        end
    endtask

    // Apply one cycle of inputs, advance the model, sample 1 time unit after the edge
    task automatic tick(input logic [8:0] b);
        {rst, en, btn_up, btn_down, btn_left, btn_right, btn_enter, btn_clear, guess_ready} = b;
        model_step(0, b);
        model_step(1, b);
        @(posedge clk);
        #1;
        check_model();
    endtask

    typedef struct {
        logic [8:0]     in;
        logic [4*D-1:0] g;
        logic [2:0]     c;
        logic           v;
    } vec_t;

    vec_t tbl[$];

    initial begin
        {rst, en, btn_up, btn_down, btn_left, btn_right, btn_enter, btn_clear, guess_ready} = '0;

        tbl.push_back('{RST,          16'h3210, 3'd3, 1'b0});
        tbl.push_back('{EN | UP,      16'h4210, 3'd3, 1'b0});
        tbl.push_back('{EN | UP,      16'h5210, 3'd3, 1'b0});
        tbl.push_back('{EN | UP,      16'h6210, 3'd3, 1'b0});
        tbl.push_back('{EN | UP,      16'h7210, 3'd3, 1'b0});
        tbl.push_back('{EN | UP,      16'h8210, 3'd3, 1'b0});
        tbl.push_back('{EN | UP,      16'h9210, 3'd3, 1'b0});
        tbl.push_back('{EN | UP,      16'h0210, 3'd3, 1'b0});
        tbl.push_back('{EN | LF,      16'h0210, 3'd0, 1'b0});
        tbl.push_back('{EN | RT,      16'h0210, 3'd3, 1'b0});
        tbl.push_back('{EN | CLR | ENT, 16'h3210, 3'd3, 1'b0});
        tbl.push_back('{EN | UP | DN, 16'h3210, 3'd3, 1'b0});
        tbl.push_back('{UP,           16'h3210, 3'd3, 1'b0});
        tbl.push_back('{EN | DN,      16'h2210, 3'd3, 1'b0});
        tbl.push_back('{EN | DN,      16'h1210, 3'd3, 1'b0});
        tbl.push_back('{EN | RT,      16'h1210, 3'd2, 1'b0});
        tbl.push_back('{EN | DN,      16'h1110, 3'd2, 1'b0});
        tbl.push_back('{EN | RT,      16'h1110, 3'd1, 1'b0});
        tbl.push_back('{EN | UP,      16'h1120, 3'd1, 1'b0});
        tbl.push_back('{EN | RT,      16'h1120, 3'd0, 1'b0});
        tbl.push_back('{EN | UP,      16'h1121, 3'd0, 1'b0});
        tbl.push_back('{EN | UP,      16'h1122, 3'd0, 1'b0});
        tbl.push_back('{EN | UP,      16'h1123, 3'd0, 1'b0});
        tbl.push_back('{EN | ENT,     16'h1123, 3'd0, !CHECK_ON});

        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].in);
            chk("tbl_guess",  32'(guess_o[0]),  32'(tbl[i].g));
            chk("tbl_cursor", 32'(cursor_o[0]), 32'(tbl[i].c));
            chk("tbl_valid",  32'(valid_o[0]),  32'(tbl[i].v));
        end

        // Duplicate enter: single-cycle error pulse and lagging mask
        chk("dup_err_pulse", 32'(dup_err_o[0]), 32'(CHECK_ON));
        tick(EN);
        chk("dup_err_one_cycle", 32'(dup_err_o[0]), 32'd0);
        chk("dup_mask_1100", 32'(dup_mask_o[0]), CHECK_ON ? 32'hC : 32'h0);

        // Offer held against pulses until ready
        tick(RST);
        tick(EN | UP);
        tick(EN | UP);
        tick(EN | ENT);
        chk("offer_valid", 32'(valid_o[0]), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick(EN | UP);
            chk("offer_hold_valid", 32'(valid_o[0]), 32'd1);
            chk("offer_hold_guess", 32'(guess_o[0]), 32'h5210);
        end
        tick(EN | RDY);
        chk("transfer_valid_low", 32'(valid_o[0]), 32'd0);
        chk("transfer_guess_kept", 32'(guess_o[0]), 32'h5210);
        tick(EN | UP);
        chk("post_transfer_edit", 32'(guess_o[0]), 32'h6210);

        // Reset during offer drops it
        tick(EN | ENT);
        chk("offer2_valid", 32'(valid_o[0]), 32'd1);
        tick(RST);
        chk("rst_offer_valid",  32'(valid_o[0]),  32'd0);
        chk("rst_offer_guess",  32'(guess_o[0]),  32'h3210);
        chk("rst_offer_cursor", 32'(cursor_o[0]), 32'd3);

        // Cursor at MSB: wrap vs saturate
        tick(EN | LF);
        chk("wrap_left",      32'(cursor_o[0]), 32'd0);
        chk("saturate_left",  32'(cursor_o[1]), 32'd3);
        tick(EN | RT);
        chk("wrap_right",     32'(cursor_o[0]), 32'd3);
        chk("saturate_right", 32'(cursor_o[1]), 32'd2);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [8:0] b;
            b[8] = ($urandom_range(0, 63) == 0);
            b[7] = ($urandom_range(0, 7) != 0);
            for (int k = 1; k < 7; k++) b[k] = ($urandom_range(0, 3) == 0);
            b[2] = b[2] && ($urandom_range(0, 1) == 0);
            b[1] = b[1] && ($urandom_range(0, 3) == 0);
            b[0] = ($urandom_range(0, 2) == 0);
            tick(b);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
